// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD text sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    INIT,
    HOME1,
    LINE1,
    HOME2,
    LINE2,
    IDLE
  } lcd_state_e;

  localparam int LINE_LEN = 16;
  localparam int INIT_LEN = 4;

  // Function set 8-bit/2-line, display on, entry mode increment, clear.
  // Entry [0] goes out first.
  localparam logic [INIT_LEN-1:0][7:0] INIT_CMDS = {8'h01, 8'h06, 8'h0C, 8'h38};

  localparam logic [7:0] LINE1_ADDR = 8'h80;
  localparam logic [7:0] LINE2_ADDR = 8'hC0;
  localparam logic [7:0] BLANK_CHAR = 8'h20;

endpackage

// File: rtl/lcd_char_buffer.sv
// Character buffer: one write port, one combinational read port, reset to blanks.
module lcd_char_buffer
  import lcd_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  // Storage: whole array blanks on reset, otherwise single-entry writes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= BLANK_CHAR;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lcd_text_sequencer.sv
// Streams init commands, then both text lines, to a ready/valid LCD writer;
// rewrites the screen whenever the buffer changes or the refresh timer expires.
module lcd_text_sequencer
  import lcd_pkg::*;
#(
  parameter int REFRESH_CYCLES = 50000000,
  parameter int CHAR_COUNT     = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_char,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_rs,
  output logic [7:0] out_data,
  output logic       init_done,
  output logic       busy
);

  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_CYCLES - 1);

  lcd_state_e  state_q, state_d;
  logic [1:0]  cmd_q, cmd_d;
  logic [3:0]  chr_q, chr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        dirty_q, dirty_d;
  logic        init_done_q, init_done_d;
  logic        vld_q, vld_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;

  logic        xfer, wr_ok;
  logic [4:0]  rd_addr;
  logic [7:0]  rd_data;

  assign xfer  = vld_q & out_ready;
  assign wr_ok = wr_en && (int'(wr_addr) < CHAR_COUNT);

  // The buffer is read at the position about to be presented, so a character
  // is captured on the edge it goes on the bus and later writes cannot touch it.
  assign rd_addr = {state_d == LINE2, chr_d};

  lcd_char_buffer #(.DEPTH(CHAR_COUNT)) u_buf (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (wr_ok),
    .waddr_i (wr_addr),
    .wdata_i (wr_char),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  // State/position advance on each accepted byte, refresh timing, dirty tracking.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    chr_d       = chr_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    dirty_d     = dirty_q;

    // A write landing with the HOME1 transfer must force another pass.
    if (xfer && state_q == HOME1) dirty_d = 1'b0;
    if (wr_ok)                    dirty_d = 1'b1;

    if (xfer) begin
      unique case (state_q)
        INIT: begin
          if (cmd_q == 2'(INIT_LEN - 1)) begin
            init_done_d = 1'b1;
            cmd_d       = '0;
            state_d     = HOME1;
          end else begin
            cmd_d = cmd_q + 2'd1;
          end
        end
        HOME1: begin
          chr_d   = '0;
          state_d = LINE1;
        end
        LINE1: begin
          chr_d = chr_q + 4'd1;
          if (chr_q == 4'(LINE_LEN - 1)) state_d = HOME2;
        end
        HOME2: begin
          chr_d   = '0;
          state_d = LINE2;
        end
        LINE2: begin
          chr_d = chr_q + 4'd1;
          if (chr_q == 4'(LINE_LEN - 1)) state_d = IDLE;
        end
        default: ;
      endcase
    end

    if (state_q == IDLE) begin
      if (dirty_q || cnt_q == REF_LAST) begin
        cnt_d   = '0;
        state_d = HOME1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Output slot: reload whenever empty or just accepted, otherwise hold steady.
  always_comb begin
    vld_d  = vld_q;
    rs_d   = rs_q;
    data_d = data_q;
    if (!vld_q || xfer) begin
      vld_d = (state_d != IDLE);
      rs_d  = (state_d == LINE1) || (state_d == LINE2);
      unique case (state_d)
        INIT:         data_d = INIT_CMDS[cmd_d];
        HOME1:        data_d = LINE1_ADDR;
        HOME2:        data_d = LINE2_ADDR;
        LINE1, LINE2: data_d = rd_data;
        default:      data_d = 8'h00;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      cmd_q       <= '0;
      chr_q       <= '0;
      cnt_q       <= '0;
      dirty_q     <= 1'b0;
      init_done_q <= 1'b0;
      vld_q       <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      chr_q       <= chr_d;
      cnt_q       <= cnt_d;
      dirty_q     <= dirty_d;
      init_done_q <= init_done_d;
      vld_q       <= vld_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
    end
  end

  assign out_valid = vld_q;
  assign out_rs    = rs_q;
  assign out_data  = data_q;
  assign init_done = init_done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Randomized bench for lcd_text_sequencer against a byte-stream model.
module tb_lcd_text_sequencer;

  localparam int R = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_char = '0;
  logic       out_ready = 1'b0;
  logic       out_valid, out_rs, init_done, busy;
  logic [7:0] out_data;

  always #5 clk = ~clk;

  lcd_text_sequencer #(.REFRESH_CYCLES(R), .CHAR_COUNT(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_char   (wr_char),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rs    (out_rs),
    .out_data  (out_data),
    .init_done (init_done),
    .busy      (busy)
  );

  // Model: queue of bytes still owed to the LCD; characters are resolved from
  // the shadow screen when they reach the head of the queue.
  typedef struct {
    bit         rs;
    logic [7:0] data;
    int         idx;
    bit         shown;
  } item_t;

  item_t      exp_q[$];
  logic [7:0] shadow [32];
  bit         m_dirty, m_init, on_air;
  int         idle_cnt;
  int         total = 0;
  int         bad = 0;
  int         stall_left = 0;
  bit         stalled = 0;
  bit         wrote41 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push_item(input bit rs, input logic [7:0] d, input int idx);
    item_t it;
    it.rs = rs; it.data = d; it.idx = idx; it.shown = 1'b0;
    exp_q.push_back(it);
  endfunction

  function automatic void push_pass();
    push_item(1'b0, 8'h80, -1);
    for (int i = 0; i < 16; i++) push_item(1'b1, 8'h00, i);
    push_item(1'b0, 8'hC0, -1);
    for (int i = 16; i < 32; i++) push_item(1'b1, 8'h00, i);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    for (int i = 0; i < 32; i++) shadow[i] = 8'h20;
    m_dirty = 0; m_init = 0; on_air = 0; idle_cnt = 0;
    push_item(1'b0, 8'h38, -1);
    push_item(1'b0, 8'h0C, -1);
    push_item(1'b0, 8'h06, -1);
    push_item(1'b0, 8'h01, -1);
    push_pass();
  endfunction

  task automatic reset_checks();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_rs", out_rs, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_busy", busy, 1'b1);
  endtask

  // Compare the current cycle against the model, then take the idle decision.
  task automatic observe();
    item_t it;
    chk("init_done", init_done, m_init);
    if (exp_q.size() != 0) begin
      it = exp_q[0];
      if (!it.shown) begin
        if (it.idx >= 0) it.data = shadow[it.idx];
        it.shown = 1'b1;
        exp_q[0] = it;
      end
      chk("valid", out_valid, 1'b1);
      chk("busy", busy, 1'b1);
      chk("rs", out_rs, it.rs);
      chk("data", out_data, it.data);
      on_air = 1'b1;
    end else begin
      chk("idle_valid", out_valid, 1'b0);
      chk("idle_busy", busy, 1'b0);
      on_air = 1'b0;
      if (m_dirty || idle_cnt == R - 1) begin
        push_pass();
        idle_cnt = 0;
      end else begin
        idle_cnt++;
      end
    end
  endtask

  // Drive this cycle's inputs and advance the model to the next edge.
  task automatic commit(input bit en, input logic [4:0] a, input logic [7:0] c, input bit rdy);
    item_t h;
    bit x;
    x = on_air && rdy;
    // Never write the cell whose byte is captured on this very edge.
    if (en && x && exp_q.size() > 1 && exp_q[1].idx == int'(a)) en = 1'b0;
    wr_en = en; wr_addr = a; wr_char = c; out_ready = rdy;
    if (x) begin
      h = exp_q.pop_front();
      if (!h.rs && h.data == 8'h80) m_dirty = 1'b0;
      if (!h.rs && h.data == 8'h01) m_init = 1'b1;
    end
    if (en) begin
      shadow[a] = c;
      m_dirty = 1'b1;
    end
  endtask

  task automatic cycle(input int mode);
    bit         en, rdy;
    logic [4:0] a;
    logic [7:0] c;
    @(negedge clk);
    observe();
    en  = 1'b0;
    rdy = 1'b1;
    a   = 5'($urandom_range(0, 31));
    c   = 8'($urandom_range(32, 126));
    case (mode)
      0: begin
        if (on_air && !exp_q[0].rs && exp_q[0].data == 8'h06 && !stalled) begin
          stall_left = 5; stalled = 1'b1;
        end
        rdy = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end
      1: begin
        rdy = ($urandom_range(0, 3) != 0);
        en  = ($urandom_range(0, 9) == 0);
      end
      2: begin
        en = on_air && !exp_q[0].rs && exp_q[0].data == 8'h80;
        a  = 5'd0;
      end
      3: begin
        rdy = $urandom_range(0, 1) != 0;
        en  = ($urandom_range(0, 29) == 0);
      end
      default: begin
        if (exp_q.size() == 0 && !wrote41) begin
          en = 1'b1; a = 5'd17; c = 8'h41; wrote41 = 1'b1;
        end
      end
    endcase
    commit(en, a, c, rdy);
  endtask

  task automatic run(input int n, input int mode);
    for (int k = 0; k < n; k++) cycle(mode);
  endtask

  initial begin
    model_reset();
    repeat (3) begin
      @(negedge clk);
      reset_checks();
    end
    rst = 1'b0;

    run(120, 0);   // clean pass with a 5-cycle stall on 0x06, then refresh
    run(100, 4);   // idle write to addr 17 triggers an immediate pass
    run(300, 1);
    run(200, 2);   // writes colliding with the HOME1 transfer
    run(400, 3);

    // Reset in the middle of a pass.
    begin
      int guard = 0;
      while (!(on_air && exp_q.size() > 10) && guard < 200) begin
        cycle(1);
        guard++;
      end
      chk("reach_pass", (on_air && exp_q.size() > 10), 1'b1);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    wr_en = 1'b0;
    #1 reset_checks();
    repeat (2) begin
      @(negedge clk);
      reset_checks();
    end
    model_reset();
    rst = 1'b0;

    run(300, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_text_sequencer.md
LCD_TEXT_SEQUENCER -- requirements
Module: lcd_text_sequencer

Interface
REQ-001 SHALL have parameter REFRESH_CYCLES, default 50000000, idle cycles before an unconditional screen rewrite.
REQ-002 SHALL have parameter CHAR_COUNT, default 32, buffer size as 2 lines x 16 characters, fixed.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  host character write strobe, one write per cycle.
REQ-006 SHALL have port wr_addr  input  5  buffer index; 0-15 is line 1, 16-31 is line 2.
REQ-007 SHALL have port wr_char  input  8  ASCII code to store.
REQ-008 SHALL have port out_valid  output  1  byte offered to the downstream LCD writer.
REQ-009 SHALL have port out_ready  input  1  downstream LCD writer accepts the byte.
REQ-010 SHALL have port out_rs  output  1  0 = command, 1 = character data.
REQ-011 SHALL have port out_data  output  8  byte offered.
REQ-012 SHALL have port init_done  output  1  init command sequence fully accepted.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL transfer a byte only on a cycle with out_valid=1 and out_ready=1.
REQ-015 SHALL hold out_valid, out_rs and out_data stable from assertion until transfer, and SHALL NOT drop out_valid without a transfer.
REQ-016 SHALL present the next byte, or deassert out_valid, on the cycle after a transfer; maximum throughput is one byte per cycle.
REQ-017 SHALL use states INIT, HOME1, LINE1, HOME2, LINE2, IDLE.
REQ-018 INIT SHALL send commands 0x38, 0x0C, 0x06, 0x01 (rs=0) in that order, then set init_done and go to HOME1.
REQ-019 HOME1 SHALL send command 0x80 and then go to LINE1.
REQ-020 LINE1 SHALL send buffer[0..15] with rs=1 and then go to HOME2.
REQ-021 HOME2 SHALL send command 0xC0 and then go to LINE2.
REQ-022 LINE2 SHALL send buffer[16..31] with rs=1 and then go to IDLE.
REQ-023 IDLE SHALL hold out_valid=0 and increment a refresh counter.
REQ-024 IDLE SHALL go to HOME1 when the dirty flag is set or the refresh counter reaches REFRESH_CYCLES-1; the counter SHALL clear on exit.
REQ-025 SHALL write wr_char to buffer[wr_addr] on a cycle with wr_en=1, in any state.
REQ-026 SHALL ignore a write with wr_addr greater than 31 and SHALL NOT set dirty for it.
REQ-027 SHALL capture a character byte from the buffer at the cycle it is first presented; a later write to the same index SHALL NOT alter the held out_data.
REQ-028 SHALL set the dirty flag on any in-range write.
REQ-029 SHALL clear the dirty flag on the cycle the HOME1 command transfers.
REQ-030 On a write and a HOME1 transfer in the same cycle, the dirty flag SHALL end set.
REQ-031 SHALL accept writes during INIT, so the first rewrite shows them.
REQ-032 SHALL keep init_done at 1 until reset.

Reset
REQ-033 While rst=1, SHALL drive out_valid=0, out_rs=0, out_data=0x00, init_done=0, busy=1.
REQ-034 While rst=1, SHALL set state=INIT, command index=0, character index=0, refresh counter=0, dirty=0.
REQ-035 While rst=1, SHALL set all 32 buffer entries to 0x20.
REQ-036 Reset mid-transfer SHALL abort the offered byte; after release the block SHALL restart at INIT and offer 0x38 on the first clock.

Structure
REQ-037 SHALL put the state enum, init command table, 0x80/0xC0 line addresses and the 0x20 blank code in package lcd_pkg.
REQ-038 SHALL put the 32x8 buffer, with reset clear and read/write ports, in sub-module lcd_char_buffer.

Verification
REQ-039 Scenario: reset, out_ready held at 1 -> bytes 38,0C,06,01,80, then 16 x 20, then C0, then 16 x 20; init_done rises after 0x01 transfers; busy falls after the 38th byte.
REQ-040 Scenario: out_ready low for 5 cycles on the 0x06 beat -> out_valid=1 and out_data=0x06 stable throughout, no byte skipped.
REQ-041 Scenario: in IDLE, write 0x41 to addr 17 -> HOME1 starts within 1 cycle; 20th byte of the pass = 0x41 with rs=1.
REQ-042 Scenario: during LINE1, write 0x5A to addr 3 after index 3 is presented -> the current pass shows 0x20; the next pass shows 0x5A.
REQ-043 Scenario: wr_en with wr_addr=0 in the same cycle as the HOME1 transfer -> dirty stays set; a second pass follows immediately.
REQ-044 Scenario: REFRESH_CYCLES=10, no writes -> a new HOME1 pass starts 10 cycles after IDLE entry; rst mid-pass -> restart at 0x38.
